// File: rtl/cpu_types_pkg.sv
// Shared types for the execute stage: data word, multiply/divide opcodes and states, ALU opcodes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    localparam logic [5:0] MDU_LAST_ITER = 6'd31;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle between a sequencer and the shared ALU.
interface alu_if;
    import cpu_types_pkg::*;

    logic [3:0] aluop;
    word_t      port_a;
    word_t      port_b;
    word_t      result;
    logic       overflow;
    logic       negative;

    modport alu  (input aluop, port_a, port_b, output result, overflow, negative);
    modport ctrl (output aluop, port_a, port_b, input result, overflow, negative);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND/OR/ADD/SUB with signed-overflow and negative flags.
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu bus
);

    always_comb begin
        bus.result   = '0;
        bus.overflow = 1'b0;
        unique case (bus.aluop)
            ALU_AND: bus.result = bus.port_a & bus.port_b;
            ALU_OR:  bus.result = bus.port_a | bus.port_b;
            ALU_ADD: begin
                bus.result   = bus.port_a + bus.port_b;
                bus.overflow = (bus.port_a[31] == bus.port_b[31]) && (bus.result[31] != bus.port_a[31]);
            end
            ALU_SUB: begin
                bus.result   = bus.port_a - bus.port_b;
                bus.overflow = (bus.port_a[31] != bus.port_b[31]) && (bus.result[31] != bus.port_a[31]);
            end
            default: bus.result = '0;
        endcase
        bus.negative = bus.result[31];
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-cycle shift-add multiplier / restoring divider sharing one ALU; results land in HI/LO.
// Normal op: done 35 cycles after start; divide-by-zero: done the next cycle. Abort returns to IDLE at once.
module muldiv_seq
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t state_q, state_d;
    mdu_op_t    op_q, op_d;
    logic [5:0] count_q, count_d;
    word_t      acc_q, acc_d;     // product high word / partial remainder
    word_t      mq_q, mq_d;       // multiplier / dividend, becomes product low / quotient
    word_t      opnd_q, opnd_d;   // multiplicand / divisor magnitude
    logic       neg_lo_q, neg_lo_d;
    logic       neg_hi_q, neg_hi_d;
    word_t      hi_q, hi_d;
    word_t      lo_q, lo_d;
    logic       dbz_q, dbz_d;

    logic [3:0] alu_op;
    word_t      alu_a, alu_b, alu_res;

    alu_if alu_bus ();
    alu u_alu (.bus(alu_bus));

    assign alu_bus.aluop  = alu_op;
    assign alu_bus.port_a = alu_a;
    assign alu_bus.port_b = alu_b;
    assign alu_res        = alu_bus.result;

    mdu_op_t op_in;
    logic    is_mul, is_signed, neg_a, neg_b;
    logic    carry, shift_out, take;
    word_t   rem_sh, quot_sh;

    assign op_in     = mdu_op_t'(op);
    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign neg_a     = is_signed && mq_q[31];
    assign neg_b     = is_signed && opnd_q[31];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        alu_op    = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        carry     = 1'b0;
        shift_out = acc_q[31];
        take      = 1'b0;
        rem_sh    = {acc_q[30:0], mq_q[31]};
        quot_sh   = {mq_q[30:0], 1'b0};

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if ((op_in == OP_DIV || op_in == OP_DIVU) && rt_val == '0) begin
                            hi_d    = rs_val;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            op_d    = op_in;
                            mq_d    = rs_val;
                            opnd_d  = rt_val;
                            dbz_d   = 1'b0;
                            state_d = ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    // ALU negates the first operand; the second needs its own negate in the same cycle
                    alu_op   = ALU_SUB;
                    alu_b    = mq_q;
                    mq_d     = neg_a ? alu_res : mq_q;
                    opnd_d   = neg_b ? (32'd0 - opnd_q) : opnd_q;
                    neg_lo_d = neg_a ^ neg_b;
                    neg_hi_d = is_mul ? (neg_a ^ neg_b) : neg_a;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = ST_ITER;
                end
                ST_ITER: begin
                    if (is_mul) begin
                        alu_op = ALU_ADD;
                        alu_a  = acc_q;
                        alu_b  = mq_q[0] ? opnd_q : '0;
                        carry  = alu_res < acc_q;
                        acc_d  = {carry, alu_res[31:1]};
                        mq_d   = {alu_res[0], mq_q[31:1]};
                    end else begin
                        alu_op = ALU_SUB;
                        alu_a  = rem_sh;
                        alu_b  = opnd_q;
                        take   = shift_out || (rem_sh >= opnd_q);
                        acc_d  = take ? alu_res : rem_sh;
                        mq_d   = {quot_sh[31:1], take};
                    end
                    count_d = count_q + 6'd1;
                    if (count_q == MDU_LAST_ITER) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    alu_op = ALU_SUB;
                    alu_b  = mq_q;
                    lo_d   = neg_lo_q ? alu_res : mq_q;
                    if (!neg_hi_q) begin
                        hi_d = acc_q;
                    end else if (is_mul) begin
                        // upper half of a 64-bit two's-complement negate
                        hi_d = ~acc_q + word_t'(mq_q == '0);
                    end else begin
                        hi_d = 32'd0 - acc_q;
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            count_q  <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the CPU execute stage. It accepts MULT/MULTU/DIV/DIVU with a start/busy/done handshake. It steps a shared `alu` instance through 32 add-or-subtract iterations and writes the 64-bit result into its HI/LO registers. Single-cycle ALU ops are unaffected; the hazard unit stalls on `busy`.

## Interface
Parameters:
- None; data width fixed at 32 (`word_t`), iteration count fixed at 32.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `abort`  in  1  cancel in-flight op (pipeline flush).
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; HI/LO valid from this cycle.
- `div_by_zero`  out  1  valid with `done`; held until next accepted start.
- `hi`  out  32  registered HI (product high word / remainder).
- `lo`  out  32  registered LO (product low word / quotient).

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP on `start`, except DIV/DIVU with `rt_val`==0: IDLE -> DONE directly, with hi=rs_val, lo=32'hFFFF_FFFF, div_by_zero=1.
- PREP: latch magnitudes. Signed ops negate negative operands via ALU SUB (0 - x). Record result sign:
  - MULT and DIV quotient: sign(a)^sign(b).
  - DIV remainder: sign(a).
  - Unsigned ops pass operands through.
- ITER, 32 cycles, counter 0..31:
  - Multiply: if multiplier LSB, acc = acc + mcand via ALU ADD (0010). Carry = (sum < acc), unsigned compare. {carry,acc,mplr} shifts right 1.
  - Divide (restoring): {rem,quot} shifts left 1, keeping the shifted-out bit b. Trial = rem - divisor via ALU SUB (0011). If b==1 or rem >= divisor (unsigned), accept the trial and set the quot LSB.
  - The ALU `overflow`/`negative` flags are ignored.
- ITER -> FIX after count 31.
- FIX: apply recorded signs.
  - 64-bit product negate: lo' = 0 - lo; hi' = ~hi + (lo==0).
  - Write hi/lo (HI=remainder, LO=quotient for divides). Then -> DONE.
- DIV 0x8000_0000 / -1 yields lo=0x8000_0000, hi=0; this case is not flagged.
- DONE: `done`=1, then unconditionally -> IDLE. `start` is ignored in DONE.
- `abort` in any non-IDLE state -> IDLE at the next edge. hi/lo/div_by_zero keep their prior values; no `done`.
- `abort` and `start` together in IDLE: abort wins, no op accepted.
- When the ALU is not sequenced, aluop is driven to ADD with zero operands.

## Timing
- Reset: state=IDLE, count=0, hi=lo=0, busy=done=div_by_zero=0. All take effect immediately, including mid-operation.
- Start sampled at edge E0.
  - Normal op: PREP after E0, ITER E1..E33, FIX after E33, result registered at E34. `done` high for the one cycle after E34, i.e. 35 cycles after E0.
  - Divide by zero: `done` high the cycle after E0.
- `busy` rises the cycle after E0 and falls the cycle after `done`.
- Back-to-back: the earliest next accept is the first cycle `busy` is low.
- hi/lo change only at the FIX edge or the divide-by-zero accept edge.

## Structure
- In `cpu_types_pkg`:
  - `mdu_op_t` (2-bit enum).
  - `mdu_state_t` (enum of the five states).
  - ALU opcode constants ALU_ADD=4'b0010, ALU_SUB=4'b0011.
  - `word_t`.
- One sub-module: `alu`, instantiated through `alu_if`, with `port_a`/`port_b`/`aluop` driven from the FSM.
- Everything else (operand registers, 6-bit counter, sign flags) lives in this module.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001. `done` exactly 35 cycles after start; `busy` high throughout.
- MULT 0xFFFF_FFFD (−3) × 7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (−21). MULT 0x8000_0000 × 0x8000_0000 -> hi=0x4000_0000, lo=0.
- DIV −7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 0xFFFF_FFFF / 0x8000_0000 -> lo=1, hi=0x7FFF_FFFF (exercises the shifted-out-bit path).
- DIVU 5 / 0 -> `done` the cycle after start, hi=5, lo=0xFFFF_FFFF, div_by_zero=1. The next normal op clears div_by_zero.
- Abort at ITER count 10 -> IDLE next cycle, no `done`, hi/lo unchanged. `start` during DONE is ignored; the following cycle's start is accepted.
- RST asserted mid-ITER between clock edges -> all outputs 0 immediately. After release, a fresh MULTU 3×4 gives lo=12, hi=0.
